keypad_scanner: RTL

//   Drives the 4x4 keypad rows (active-low, one-hot) and decodes the synchronized column inputs

---
 rtl/keypad_scanner.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad row scanner with debounced hex key decode
module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW  = $clog2(SCAN_DIV);
    localparam int DBW = $clog2(DEBOUNCE_CYC);

    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0]  DWELL_ONE  = DW'(1);
    localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYC - 1);
    localparam logic [DBW-1:0] DB_ONE     = DBW'(1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     row_q, row_d;
    logic [3:0]     pat_q, pat_d;
    logic [3:0]     key_q, key_d;
    logic           key_valid_q, key_valid_d;
    logic           key_held_q, key_held_d;
    logic [DW-1:0]  dwell_q, dwell_d;
    logic [DBW-1:0] db_q, db_d;

    logic [1:0]     row_idx;
    logic [1:0]     col_idx;
    logic [3:0]     map_code;
    logic           row_legal;
    logic [3:0]     row_next;
    logic           col_one_low;

    // Decode the frozen row, the latched column pattern and the incoming column pattern
    always_comb begin
        row_idx     = 2'd0;
        row_legal   = 1'b1;
        col_idx     = 2'd0;
        col_one_low = 1'b0;
        case (row_q)
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_legal = 1'b0;
        endcase
        case (pat_q)
            4'b1110: col_idx = 2'd0;
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
        case (col)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: col_one_low = 1'b1;
            default:                            col_one_low = 1'b0;
        endcase
        // A corrupted row register restarts the scan at the top row
        row_next = row_legal ? {row_q[2:0], row_q[3]} : 4'b1110;
    end

    // Keypad legend lookup for the latched row/column
    always_comb begin
        map_code = 4'h0;
        case ({row_idx, col_idx})
            4'b00_00: map_code = 4'h1;
            4'b00_01: map_code = 4'h2;
            4'b00_10: map_code = 4'h3;
            4'b00_11: map_code = 4'hA;
            4'b01_00: map_code = 4'h4;
            4'b01_01: map_code = 4'h5;
            4'b01_10: map_code = 4'h6;
            4'b01_11: map_code = 4'hB;
            4'b10_00: map_code = 4'h7;
            4'b10_01: map_code = 4'h8;
            4'b10_10: map_code = 4'h9;
            4'b10_11: map_code = 4'hC;
            4'b11_00: map_code = 4'hE;
            4'b11_01: map_code = 4'h0;
            4'b11_10: map_code = 4'hF;
            4'b11_11: map_code = 4'hD;
            default:  map_code = 4'h0;
        endcase
    end

    // Scan / debounce / hold / release sequencing
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        pat_d       = pat_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        dwell_d     = dwell_q;
        db_d        = db_q;
        case (state_q)
            ST_SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    if (col_one_low) begin
                        pat_d   = col;
                        db_d    = '0;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        row_d   = row_next;
                        dwell_d = '0;
                    end
                end else begin
                    dwell_d = dwell_q + DWELL_ONE;
                end
            end
            ST_DEBOUNCE: begin
                if (col == pat_q) begin
                    if (db_q == DB_LAST) begin
                        key_d       = map_code;
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                        state_d     = ST_HELD;
                    end else begin
                        db_d = db_q + DB_ONE;
                    end
                end else begin
                    // Bounce: rescan the same row from a fresh settle dwell
                    state_d = ST_SCAN;
                    dwell_d = '0;
                end
            end
            ST_HELD: begin
                if (col == 4'hF) begin
                    db_d    = '0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (col == 4'hF) begin
                    if (db_q == DB_LAST) begin
                        key_held_d = 1'b0;
                        state_d    = ST_SCAN;
                        row_d      = row_next;
                        dwell_d    = '0;
                    end else begin
                        db_d = db_q + DB_ONE;
                    end
                end else begin
                    state_d = ST_HELD;
                end
            end
            default: begin
                state_d    = ST_SCAN;
                row_d      = 4'b1110;
                dwell_d    = '0;
                db_d       = '0;
                key_held_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_SCAN;
            row_q       <= 4'b1110;
            pat_q       <= 4'hF;
            key_q       <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            dwell_q     <= '0;
            db_q        <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            pat_q       <= pat_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            dwell_q     <= dwell_d;
            db_q        <= db_d;
        end
    end

    assign row       = row_q;
    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule
